anton_neopixel_sequencer: RTL and testbench

//  Upstream timing sequencer for the neopixel stream stage. Walks pattern-slot, bit, channel and pixel

---
 rtl/anton_neopixel_sequencer_pkg.sv | 17 +
 rtl/anton_neopixel_sequencer_reset_timer.sv | 32 +++
 rtl/anton_neopixel_sequencer.sv | 150 +++++++++++++++
 tb/tb_anton_neopixel_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared types and defaults for the neopixel timing sequencer.
package anton_neopixel_sequencer_pkg;

  localparam int BUFFER_END_DEFAULT   = 63;
  localparam int RESET_CYCLES_DEFAULT = 400;

  // Matches the stream stage's encoding of its output state.
  typedef enum logic {
    ST_RESET    = 1'b0,
    ST_TRANSMIT = 1'b1
  } seq_state_e;

  localparam logic [1:0] CHANNEL_LAST = 2'd2;
  localparam logic [2:0] BIT_FIRST    = 3'd7;
  localparam logic [2:0] SLOT_LAST    = 3'd7;

endpackage

// File: rtl/anton_neopixel_sequencer_reset_timer.sv
// Latch-gap timer: counts clk cycles spent in RESET and saturates on the last one.
module anton_neopixel_reset_timer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  output logic expired
);

  localparam int RESET_BITS = $clog2(RESET_CYCLES + 1);
  localparam logic [RESET_BITS-1:0] COUNT_LAST = RESET_BITS'(RESET_CYCLES - 1);

  logic [RESET_BITS-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != COUNT_LAST) begin
      r_count <= r_count + RESET_BITS'(1);
    end
  end

  assign expired = (r_count == COUNT_LAST);

endmodule

// File: rtl/anton_neopixel_sequencer.sv
// Neopixel timing sequencer: walks slot/bit/channel/pixel counters, inserts the
// latch gap between frames and presents the pixel buffer address.
module anton_neopixel_sequencer
  import anton_neopixel_sequencer_pkg::*;
#(
  parameter  int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter  int RESET_CYCLES = RESET_CYCLES_DEFAULT,
  localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrl32bit,
  input  logic [BUFFER_BITS-1:0] regMax,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [1:0]             channelIndex,
  output logic [2:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic [BUFFER_BITS-1:0] bufferAddr,
  output logic                   streamSyncOf,
  output logic                   streamDone
);

  localparam logic [BUFFER_BITS-1:0] MAX_PIXEL_8  = BUFFER_BITS'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] MAX_PIXEL_32 = BUFFER_BITS'((BUFFER_END + 1) / 4 - 1);

  seq_state_e             r_state,  w_state_nxt;
  logic [BUFFER_BITS-1:0] r_pixel,  w_pixel_nxt;
  logic [1:0]             r_channel, w_channel_nxt;
  logic [2:0]             r_bit,    w_bit_nxt;
  logic [2:0]             r_slot,   w_slot_nxt;
  logic                   r_frame_seen, w_frame_seen_nxt;
  logic                   r_done,   w_done_nxt;

  logic [BUFFER_BITS-1:0] w_max_cap;
  logic [BUFFER_BITS-1:0] w_max_eff;
  logic                   w_bit_last;
  logic                   w_pixel_last;
  logic                   w_frame_end;
  logic                   w_timer_clear;
  logic                   w_timer_expired;

  anton_neopixel_reset_timer #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_reset_timer (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (w_timer_clear),
    .expired (w_timer_expired)
  );

  // Clamping the last pixel keeps every address inside the buffer in both modes.
  assign w_max_cap    = regCtrl32bit ? MAX_PIXEL_32 : MAX_PIXEL_8;
  assign w_max_eff    = (regMax > w_max_cap) ? w_max_cap : regMax;
  assign w_bit_last   = (r_slot == SLOT_LAST) && (r_bit == 3'd0);
  assign w_pixel_last = w_bit_last && (r_channel == CHANNEL_LAST);
  assign w_frame_end  = (r_state == ST_TRANSMIT) && w_pixel_last && (r_pixel >= w_max_eff);

  assign w_timer_clear = !regCtrlRun || (r_state == ST_TRANSMIT);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_pixel_nxt      = r_pixel;
    w_channel_nxt    = r_channel;
    w_bit_nxt        = r_bit;
    w_slot_nxt       = r_slot;
    w_frame_seen_nxt = r_frame_seen;
    w_done_nxt       = r_done;

    if (!regCtrlRun) begin
      w_state_nxt      = ST_RESET;
      w_pixel_nxt      = '0;
      w_channel_nxt    = '0;
      w_bit_nxt        = BIT_FIRST;
      w_slot_nxt       = '0;
      w_frame_seen_nxt = 1'b0;
      w_done_nxt       = 1'b0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (w_timer_expired) begin
            if (regCtrlLoop || !r_frame_seen) begin
              w_state_nxt = ST_TRANSMIT;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
        ST_TRANSMIT: begin
          if (w_frame_end) begin
            w_state_nxt      = ST_RESET;
            w_pixel_nxt      = '0;
            w_channel_nxt    = '0;
            w_bit_nxt        = BIT_FIRST;
            w_slot_nxt       = '0;
            w_frame_seen_nxt = 1'b1;
          end else begin
            w_slot_nxt = r_slot + 3'd1;
            if (r_slot == SLOT_LAST) begin
              w_bit_nxt = r_bit - 3'd1;
              if (r_bit == 3'd0) begin
                if (r_channel == CHANNEL_LAST) begin
                  w_channel_nxt = '0;
                  w_pixel_nxt   = r_pixel + BUFFER_BITS'(1);
                end else begin
                  w_channel_nxt = r_channel + 2'd1;
                end
              end
            end
          end
        end
        default: w_state_nxt = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_RESET;
      r_pixel      <= '0;
      r_channel    <= '0;
      r_bit        <= BIT_FIRST;
      r_slot       <= '0;
      r_frame_seen <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pixel      <= w_pixel_nxt;
      r_channel    <= w_channel_nxt;
      r_bit        <= w_bit_nxt;
      r_slot       <= w_slot_nxt;
      r_frame_seen <= w_frame_seen_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign state           = r_state;
  assign pixelIndex      = r_pixel;
  assign channelIndex    = r_channel;
  assign pixelBitIndex   = r_bit;
  assign bitPatternIndex = r_slot;
  assign bufferAddr      = regCtrl32bit ? {r_pixel[BUFFER_BITS-3:0], r_channel} : r_pixel;
  assign streamSyncOf    = w_frame_end;
  assign streamDone      = r_done;

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Scoreboard bench for anton_neopixel_sequencer: a frame-position reference model
// pushes per-cycle expectations, a negedge monitor pops and compares them.
module tb_anton_neopixel_sequencer;
  import anton_neopixel_sequencer_pkg::*;

  localparam int BE      = BUFFER_END_DEFAULT;
  localparam int RC      = RESET_CYCLES_DEFAULT;
  localparam int BB      = $clog2(BE + 1);
  localparam int PIX_CYC = 192;

  logic          clk = 1'b0;
  logic          resetN;
  logic          regCtrlRun;
  logic          regCtrlLoop;
  logic          regCtrl32bit;
  logic [BB-1:0] regMax;
  logic          state;
  logic [BB-1:0] pixelIndex;
  logic [1:0]    channelIndex;
  logic [2:0]    pixelBitIndex;
  logic [2:0]    bitPatternIndex;
  logic [BB-1:0] bufferAddr;
  logic          streamSyncOf;
  logic          streamDone;

  anton_neopixel_sequencer dut (
    .clk             (clk),
    .resetN          (resetN),
    .regCtrlRun      (regCtrlRun),
    .regCtrlLoop     (regCtrlLoop),
    .regCtrl32bit    (regCtrl32bit),
    .regMax          (regMax),
    .state           (state),
    .pixelIndex      (pixelIndex),
    .channelIndex    (channelIndex),
    .pixelBitIndex   (pixelBitIndex),
    .bitPatternIndex (bitPatternIndex),
    .bufferAddr      (bufferAddr),
    .streamSyncOf    (streamSyncOf),
    .streamDone      (streamDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st;
    int pixel;
    int ch;
    int bitn;
    int slot;
    int addr;
    bit sync;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: position is either a gap count or a slot offset inside the frame.
  bit m_tx;
  int m_gap;
  int m_t;
  bit m_seen;
  bit m_done;

  function automatic int max_eff(input bit b32, input int mx);
    int cap;
    cap = b32 ? (BE + 1) / 4 - 1 : BE;
    return (mx > cap) ? cap : mx;
  endfunction

  function automatic exp_t expect_now(input bit b32, input int mx);
    exp_t e;
    e.st   = m_tx;
    e.done = m_done;
    if (!m_tx) begin
      e.pixel = 0; e.ch = 0; e.bitn = 7; e.slot = 0; e.addr = 0; e.sync = 1'b0;
    end else begin
      e.pixel = m_t / PIX_CYC;
      e.ch    = (m_t % PIX_CYC) / 64;
      e.bitn  = 7 - (m_t % 64) / 8;
      e.slot  = m_t % 8;
      e.addr  = b32 ? e.pixel * 4 + e.ch : e.pixel;
      e.sync  = (e.pixel >= max_eff(b32, mx)) && (m_t % PIX_CYC == PIX_CYC - 1);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_tx = 1'b0; m_gap = 0; m_t = 0; m_seen = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit run, input bit loop, input bit b32, input int mx);
    if (!run) begin
      model_reset();
    end else if (!m_tx) begin
      if (m_gap == RC - 1) begin
        if (loop || !m_seen) begin
          m_tx = 1'b1;
          m_t  = 0;
        end else begin
          m_done = 1'b1;
        end
      end else begin
        m_gap++;
      end
    end else if ((m_t / PIX_CYC >= max_eff(b32, mx)) && (m_t % PIX_CYC == PIX_CYC - 1)) begin
      m_tx   = 1'b0;
      m_gap  = 0;
      m_seen = 1'b1;
    end else begin
      m_t++;
    end
  endtask

  task automatic check(input string name, input exp_t e);
    bit ok;
    n_vec++;
    ok = (state === e.st) && (int'(pixelIndex) == e.pixel) && (int'(channelIndex) == e.ch) &&
         (int'(pixelBitIndex) == e.bitn) && (int'(bitPatternIndex) == e.slot) &&
         (int'(bufferAddr) == e.addr) && (int'(bufferAddr) <= BE) &&
         (streamSyncOf === e.sync) && (streamDone === e.done);
    if (!ok) begin
      n_miss++;
      $display("FAIL %s t=%0t got st=%0b px=%0d ch=%0d bit=%0d slot=%0d addr=%0d sync=%0b done=%0b want st=%0b px=%0d ch=%0d bit=%0d slot=%0d addr=%0d sync=%0b done=%0b",
               name, $time, state, pixelIndex, channelIndex, pixelBitIndex, bitPatternIndex,
               bufferAddr, streamSyncOf, streamDone, e.st, e.pixel, e.ch, e.bitn, e.slot,
               e.addr, e.sync, e.done);
    end
  endtask

  // Called one time unit after a rising edge; returns at the same phase n cycles later.
  task automatic apply(input bit run, input bit loop, input bit b32, input int mx, input int n);
    for (int i = 0; i < n; i++) begin
      regCtrlRun   = run;
      regCtrlLoop  = loop;
      regCtrl32bit = b32;
      regMax       = BB'(mx);
      exp_q.push_back(expect_now(b32, mx));
      @(posedge clk);
      #1;
      model_step(run, loop, b32, mx);
    end
  endtask

  always @(negedge clk) begin
    if (resetN && exp_q.size() > 0) begin
      check("cycle", exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got no finish, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit loop_r, b32_r;
    int mx_r, mx2_r;

    resetN       = 1'b0;
    regCtrlRun   = 1'b1;
    regCtrlLoop  = 1'b0;
    regCtrl32bit = 1'b0;
    regMax       = BB'(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;

    // One-shot 8bit frame of two pixels, then done.
    apply(1, 0, 0, 1, RC + 2 * PIX_CYC + RC + 20);
    apply(0, 0, 0, 1, 2);

    // 32bit single pixel: addresses 0,1,2 only.
    apply(1, 0, 1, 0, RC + PIX_CYC + RC + 10);
    apply(0, 0, 1, 0, 2);

    // Looping three-pixel frames back to back with the gap between them.
    apply(1, 1, 0, 2, RC + 3 * (3 * PIX_CYC + RC) + 50);
    apply(0, 1, 0, 2, 2);

    // Abort at pixel 1, channel 1, then restart with a full gap.
    apply(1, 0, 0, 3, RC + PIX_CYC + 64 + 10);
    apply(0, 0, 0, 3, 1);
    apply(1, 0, 0, 3, RC + 200);

    // Asynchronous reset between edges while transmitting.
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    check("async_reset", expect_now(1'b0, 3));
    @(posedge clk);
    #1;
    resetN = 1'b1;
    apply(0, 0, 0, 3, 2);

    // Full-buffer request in 32bit mode is clamped to the last whole pixel.
    apply(1, 0, 1, BE, RC + ((BE + 1) / 4) * PIX_CYC + RC + 10);
    apply(0, 0, 1, BE, 2);

    // Random configurations, occasionally moving regMax mid-run.
    for (int k = 0; k < 6; k++) begin
      loop_r = 1'($urandom_range(0, 1));
      b32_r  = 1'($urandom_range(0, 1));
      mx_r   = int'($urandom_range(0, BE));
      mx2_r  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BE)) : mx_r;
      apply(1, loop_r, b32_r, mx_r, int'($urandom_range(200, 1500)));
      apply(1, loop_r, b32_r, mx2_r, int'($urandom_range(200, 1500)));
      apply(0, loop_r, b32_r, mx2_r, int'($urandom_range(1, 3)));
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
